// File: rtl/spi_byte_engine_if.sv
// FIFO-side handshake bundle for the SPI byte engine: TX FIFO read port
// (show-ahead) and RX FIFO write port.
interface spi_byte_engine_if;
  logic [7:0] tx_q;
  logic       tx_empty;
  logic       tx_rdreq;
  logic [7:0] rx_data;
  logic       rx_wrreq;
  logic       rx_full;

  // Engine side
  modport master (
    input  tx_q, tx_empty, rx_full,
    output tx_rdreq, rx_data, rx_wrreq
  );

  // FIFO side
  modport slave (
    output tx_q, tx_empty, rx_full,
    input  tx_rdreq, rx_data, rx_wrreq
  );
endinterface

// File: rtl/spi_byte_engine.sv
// SPI mode-0 master shift stage: pops a byte from the TX FIFO, shifts it out
// MSB-first while capturing MISO, then pushes the received byte to the RX FIFO.
module spi_byte_engine #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  input  logic             rx_discard,
  spi_byte_engine_if.master fifo,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic [7:0]       rx_data_r;
  logic             rx_wrreq_r;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] hcnt;
  logic [2:0]       bit_cnt;
  logic             disc_l;
  logic             start;

  // RX space is checked up front so the push at the end can never overflow.
  assign start = (state == S_IDLE) && enable && !fifo.tx_empty &&
                 (rx_discard || !fifo.rx_full);

  assign fifo.tx_rdreq = start;
  assign fifo.rx_data  = rx_data_r;
  assign fifo.rx_wrreq = rx_wrreq_r;
  assign busy          = (state != S_IDLE);
  // MOSI is presented from the pop onward, a full half period before SCK rises.
  assign mosi          = (state == S_IDLE) ? 1'b1 : tx_sh[7];

  // Byte sequencer: half-period counting, shifting and end-of-byte push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sck        <= 1'b0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_wrreq_r <= 1'b0;
      div_l      <= '0;
      hcnt       <= '0;
      bit_cnt    <= 3'd0;
      disc_l     <= 1'b0;
    end else begin
      rx_wrreq_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_sh   <= fifo.tx_q;
            div_l   <= divider;
            disc_l  <= rx_discard;
            bit_cnt <= 3'd7;
            hcnt    <= divider;
            state   <= S_LOW;
          end
        end
        S_LOW: begin
          if (hcnt == '0) begin
            sck   <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso};
            hcnt  <= div_l;
            state <= S_HIGH;
          end else begin
            hcnt <= hcnt - DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (hcnt == '0) begin
            sck  <= 1'b0;
            hcnt <= div_l;
            if (bit_cnt == 3'd0) begin
              // Result is registered here so it is stable during DONE.
              rx_data_r  <= rx_sh;
              rx_wrreq_r <= !disc_l;
              state      <= S_DONE;
            end else begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              state   <= S_LOW;
            end
          end else begin
            hcnt <= hcnt - DIV_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench for spi_byte_engine: TX/RX FIFO models, SCK/pop/push
// monitor, and per-scenario tasks compared against expected byte timing.
module tb_spi_byte_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] divider;
  logic       rx_discard;
  logic       sck, mosi, busy;
  logic       loop;
  logic       miso_fix;
  logic       miso;
  logic       rx_full_r;
  logic       tx_empty_r;
  logic [7:0] tx_q_r;

  spi_byte_engine_if fif();

  assign fif.tx_q     = tx_q_r;
  assign fif.tx_empty = tx_empty_r;
  assign fif.rx_full  = rx_full_r;
  assign miso         = loop ? mosi : miso_fix;

  spi_byte_engine #(.DIV_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .divider    (divider),
    .rx_discard (rx_discard),
    .fifo       (fif.master),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state
  logic [7:0] txq[$];
  int         cyc = 0;
  int         rises = 0;
  int         busy_cyc = 0;
  int         run = 0;
  logic       prev_sck = 1'b0;
  bit         pop_pend = 1'b0;
  int         pop_t[$];
  int         push_t[$];
  logic [7:0] rx_q[$];
  int         hi_runs[$];
  int         lo_runs[$];

  // Sample everything on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (fif.tx_rdreq) begin
        pop_t.push_back(cyc);
        pop_pend = 1'b1;
      end
      if (fif.rx_wrreq) begin
        push_t.push_back(cyc);
        rx_q.push_back(fif.rx_data);
      end
      if (busy) busy_cyc++;
    end
    if (sck !== prev_sck) begin
      if (sck) begin
        rises++;
        lo_runs.push_back(run);
      end else begin
        hi_runs.push_back(run);
      end
      run = 1;
    end else begin
      run++;
    end
    prev_sck = sck;
  end

  // TX FIFO model: pop after the edge that consumed the head byte.
  always begin
    @(posedge clk);
    #2;
    if (pop_pend) begin
      if (txq.size() > 0) txq.delete(0);
      pop_pend = 1'b0;
    end
    tx_empty_r = (txq.size() == 0);
    tx_q_r     = (txq.size() > 0) ? txq[0] : 8'hFF;
  end

  task automatic push_tx(input logic [7:0] b);
    txq.push_back(b);
    tx_empty_r = 1'b0;
    tx_q_r     = txq[0];
  endtask

  task automatic flush_tx();
    txq.delete();
    tx_empty_r = 1'b1;
    tx_q_r     = 8'hFF;
  endtask

  task automatic clear_logs();
    pop_t.delete(); push_t.delete(); rx_q.delete();
    hi_runs.delete(); lo_runs.delete();
    rises = 0; busy_cyc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for n pops and the engine returning idle; ok=0 on budget expiry.
  task automatic wait_idle(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (pop_t.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick(2);
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (rises >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; divider = 8'd0; rx_discard = 1'b0;
    loop = 1'b1; miso_fix = 1'b0; rx_full_r = 1'b0;
    flush_tx();
    tick(3);
    total++; if (sck !== 1'b0)  begin bad++; $display("FAIL reset_sck got=%b exp=0", sck); end
    total++; if (mosi !== 1'b1) begin bad++; $display("FAIL reset_mosi got=%b exp=1", mosi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (fif.rx_wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq got=%b exp=0", fif.rx_wrreq); end
    total++; if (fif.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rxdata got=%h exp=00", fif.rx_data); end
    reset_n = 1'b1;
    tick(2);
    total++; if (fif.tx_rdreq !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle rdreq=%b busy=%b exp=0/0", fif.tx_rdreq, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    divider = 8'd0; rx_discard = 1'b0; loop = 1'b1;
    push_tx(8'hA5);
    enable = 1'b1;
    wait_idle(1, 100, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
    total++; if (pop_t.size() != 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", pop_t.size()); end
    total++; if (hi_runs.size() != 8) begin bad++; $display("FAIL single_pulses got=%0d exp=8", hi_runs.size()); end
    for (int i = 0; i < hi_runs.size(); i++) begin
      total++; if (hi_runs[i] != 1) begin bad++; $display("FAIL single_high[%0d] got=%0d exp=1", i, hi_runs[i]); end
    end
    for (int i = 1; i < lo_runs.size(); i++) begin
      total++; if (lo_runs[i] != 1) begin bad++; $display("FAIL single_low[%0d] got=%0d exp=1", i, lo_runs[i]); end
    end
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      bad++; $display("FAIL single_rx got_n=%0d exp=1 byte A5", rx_q.size());
    end
    if (push_t.size() == 1 && pop_t.size() == 1) begin
      total++; if (push_t[0] - pop_t[0] != 17) begin
        bad++; $display("FAIL single_latency got=%0d exp=17", push_t[0] - pop_t[0]);
      end
    end
    total++; if (busy_cyc != 17) begin bad++; $display("FAIL single_busy got=%0d exp=17", busy_cyc); end
    total++; if (mosi !== 1'b1) begin bad++; $display("FAIL single_mosi_idle got=%b exp=1", mosi); end
  endtask

  task automatic test_discard();
    bit ok;
    clear_logs();
    divider = 8'd0; rx_discard = 1'b1; loop = 1'b0; miso_fix = 1'b0;
    push_tx(8'h3C);
    enable = 1'b1;
    wait_idle(1, 100, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL discard_timeout got=busy exp=idle"); end
    total++; if (hi_runs.size() != 8) begin bad++; $display("FAIL discard_pulses got=%0d exp=8", hi_runs.size()); end
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL discard_push got=%0d exp=0", rx_q.size()); end
    clear_logs();
    rx_discard = 1'b0; miso_fix = 1'b1;
    push_tx(8'($urandom));
    enable = 1'b1;
    wait_idle(1, 100, ok);
    enable = 1'b0;
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hFF) begin
      bad++; $display("FAIL discard_next_rx got_n=%0d exp=1 byte FF", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hFF;
    clear_logs();
    divider = 8'd3; rx_discard = 1'b0; loop = 1'b1;
    for (int i = 0; i < 3; i++) push_tx(exp_b[i]);
    enable = 1'b1;
    wait_idle(3, 400, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=busy exp=idle"); end
    total++; if (pop_t.size() != 3) begin bad++; $display("FAIL b2b_pops got=%0d exp=3", pop_t.size()); end
    for (int i = 1; i < pop_t.size(); i++) begin
      total++; if (pop_t[i] - pop_t[i-1] != 66) begin
        bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=66", i, pop_t[i] - pop_t[i-1]);
      end
    end
    total++; if (hi_runs.size() != 24) begin bad++; $display("FAIL b2b_pulses got=%0d exp=24", hi_runs.size()); end
    for (int i = 0; i < hi_runs.size(); i++) begin
      if (hi_runs[i] != 4) begin
        total++; bad++; $display("FAIL b2b_high[%0d] got=%0d exp=4", i, hi_runs[i]);
      end
    end
    for (int i = 1; i < lo_runs.size(); i++) begin
      if (i % 8 != 0 && lo_runs[i] != 4) begin
        total++; bad++; $display("FAIL b2b_low[%0d] got=%0d exp=4", i, lo_runs[i]);
      end
    end
    total++; if (rx_q.size() != 3) begin bad++; $display("FAIL b2b_rx_n got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 3; i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin
        bad++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, rx_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int rel;
    logic [7:0] b;
    clear_logs();
    b = 8'($urandom);
    divider = 8'd0; rx_discard = 1'b0; loop = 1'b1; rx_full_r = 1'b1;
    push_tx(b);
    enable = 1'b1;
    tick(50);
    total++; if (pop_t.size() != 0) begin bad++; $display("FAIL stall_pop got=%0d exp=0", pop_t.size()); end
    total++; if (rises != 0 || sck !== 1'b0) begin bad++; $display("FAIL stall_sck got=%0d exp=0", rises); end
    rx_full_r = 1'b0;
    rel = cyc + 1;
    wait_idle(1, 100, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=busy exp=idle"); end
    total++; if (pop_t.size() != 1 || pop_t[0] != rel) begin
      bad++; $display("FAIL stall_release_pop got_n=%0d exp=1 at %0d", pop_t.size(), rel);
    end
    total++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
      bad++; $display("FAIL stall_rx got_n=%0d exp=1 byte %h", rx_q.size(), b);
    end
  endtask

  task automatic test_midbyte();
    bit ok;
    logic [7:0] a;
    a = 8'($urandom);
    clear_logs();
    divider = 8'd0; rx_discard = 1'b0; loop = 1'b1;
    push_tx(a);
    push_tx(8'($urandom));
    enable = 1'b1;
    wait_rises(3, 100, ok);
    divider = 8'd5;
    enable  = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL mid_rises_timeout got=%0d exp=3", rises); end
    wait_idle(1, 100, ok);
    tick(40);
    total++; if (hi_runs.size() != 8) begin bad++; $display("FAIL mid_pulses got=%0d exp=8", hi_runs.size()); end
    for (int i = 0; i < hi_runs.size(); i++) begin
      if (hi_runs[i] != 1) begin
        total++; bad++; $display("FAIL mid_high[%0d] got=%0d exp=1", i, hi_runs[i]);
      end
    end
    total++; if (rx_q.size() != 1 || rx_q[0] !== a) begin
      bad++; $display("FAIL mid_rx got_n=%0d exp=1 byte %h", rx_q.size(), a);
    end
    total++; if (pop_t.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_no_new_pop got=%0d exp=1", pop_t.size());
    end
    flush_tx();
    divider = 8'd0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] y;
    y = 8'($urandom);
    clear_logs();
    divider = 8'd1; rx_discard = 1'b0; loop = 1'b1;
    push_tx(8'($urandom));
    push_tx(y);
    enable = 1'b1;
    wait_rises(4, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_rises_timeout got=%0d exp=4", rises); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (sck !== 1'b0 || mosi !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got=sck%b mosi%b busy%b exp=0/1/0", sck, mosi, busy);
    end
    tick(3);
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rstmid_push got=%0d exp=0", rx_q.size()); end
    clear_logs();
    reset_n = 1'b1;
    wait_idle(1, 200, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=busy exp=idle"); end
    total++; if (pop_t.size() != 1 || hi_runs.size() != 8) begin
      bad++; $display("FAIL rstmid_next got_pops=%0d pulses=%0d exp=1/8", pop_t.size(), hi_runs.size());
    end
    total++; if (rx_q.size() != 1 || rx_q[0] !== y) begin
      bad++; $display("FAIL rstmid_rx got_n=%0d exp=1 byte %h", rx_q.size(), y);
    end
  endtask

  // Random bytes, dividers and discard, each compared against the byte-level
  // rules: 8 pulses of div+1 high, loopback data, pop-to-push 16*(div+1)+1.
  task automatic test_random();
    bit ok;
    int d;
    logic [7:0] b;
    logic disc;
    for (int n = 0; n < 6; n++) begin
      d    = $urandom_range(0, 3);
      b    = 8'($urandom);
      disc = 1'($urandom_range(0, 1));
      clear_logs();
      divider = 8'(d); rx_discard = disc; loop = 1'b1;
      push_tx(b);
      enable = 1'b1;
      tick(1);
      rx_discard = ~disc;
      divider    = 8'($urandom_range(0, 7));
      wait_idle(1, 300, ok);
      enable = 1'b0;
      total++; if (!ok || hi_runs.size() != 8) begin
        bad++; $display("FAIL rand%0d_pulses got=%0d exp=8", n, hi_runs.size());
      end
      for (int i = 0; i < hi_runs.size(); i++) begin
        if (hi_runs[i] != d + 1) begin
          total++; bad++; $display("FAIL rand%0d_high[%0d] got=%0d exp=%0d", n, i, hi_runs[i], d + 1);
        end
      end
      if (disc) begin
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rand%0d_discard got=%0d exp=0", n, rx_q.size()); end
      end else begin
        total++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
          bad++; $display("FAIL rand%0d_rx got_n=%0d exp=1 byte %h", n, rx_q.size(), b);
        end
        if (rx_q.size() == 1 && pop_t.size() == 1) begin
          total++; if (push_t[0] - pop_t[0] != 16 * (d + 1) + 1) begin
            bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, push_t[0] - pop_t[0], 16 * (d + 1) + 1);
          end
        end
      end
    end
  endtask

  initial begin
    tx_empty_r = 1'b1;
    tx_q_r     = 8'hFF;
    test_reset();
    test_single();
    test_discard();
    test_back_to_back();
    test_stall();
    test_midbyte();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
